// File: rtl/uart_pkg.sv
// Shared receiver types and default constants for the UART slice.
// Optional build macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bus: received word, event pulses and busy flag.
// Optional build macro: UART_RX_PARITY_EN (adds parity_err).
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input frame_err,
`ifdef UART_RX_PARITY_EN
        input parity_err,
`endif
        input busy
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level; resets to 1 (line idle).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-edge detect, mid-bit sampling, stop check.
// Optional build macro: UART_RX_PARITY_EN (parity bit between data and stop).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nx;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic                 half_pt;
    logic                 full_pt;
    logic [TCW-1:0]       tick_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err_q;
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) rx_prev <= 1'b1;
        else     rx_prev <= rx_s;
    end

    always_comb begin
        fall    = rx_prev & ~rx_s;
        half_pt = tick && (tick_cnt == HALF_LAST);
        full_pt = tick && (tick_cnt == FULL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (fall)    state_nx = START;
            START:  if (half_pt) state_nx = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (full_pt && (bit_cnt == LAST_BIT)) state_nx = PARITY;
            PARITY: if (full_pt) state_nx = STOP;
`else
            DATA:   if (full_pt && (bit_cnt == LAST_BIT)) state_nx = STOP;
`endif
            STOP:   if (full_pt) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad = 1'b0;
`endif

    // Counters and result registers; pulses default low so each lasts one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (half_pt)   tick_cnt <= '0;
                    else if (tick) tick_cnt <= tick_cnt + TCW'(1);
                end
                DATA: begin
                    if (full_pt) begin
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + BCW'(1);
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TCW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (full_pt) begin
                        par_bad  <= rx_s ^ (^shreg) ^ PARITY_ODD;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TCW'(1);
                    end
                end
`endif
                STOP: begin
                    if (full_pt) begin
                        tick_cnt <= '0;
                        if (rx_s && !par_bad) begin
                            rx_data_q  <= shreg;
                            rx_valid_q <= 1'b1;
                        end
                        frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.rx_data   = rx_data_q;
        bus.rx_valid  = rx_valid_q;
        bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
        bus.parity_err = parity_err_q;
`endif
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames.
// Optional build macro: UART_RX_PARITY_EN (parity bit sent and checked).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DB      = 8;
    localparam int OS      = 16;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic rx = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [DB-1:0] model_data = '0;

    uart_rx_if #(.DATA_BITS(DB)) bus_if ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .rx   (rx),
        .bus  (bus_if)
    );

    always #10 clk = ~clk;

    initial begin
        int tdiv;
        tdiv = 0;
        forever begin
            @(negedge clk);
            tick = (tdiv == 0);
            tdiv = (tdiv + 1) % 4;
        end
    end

    // Event monitor: every high cycle of a pulse is one recorded event.
    logic [DB-1:0] got_q[$];
    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_both  = 0;

    always @(negedge clk) begin
        if (bus_if.rx_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(bus_if.rx_data);
        end
        if (bus_if.frame_err === 1'b1) n_ferr++;
        if (bus_if.rx_valid === 1'b1 && bus_if.frame_err === 1'b1) n_both++;
`ifdef UART_RX_PARITY_EN
        if (bus_if.parity_err === 1'b1) n_perr++;
`endif
    end

    function automatic logic cur_perr();
`ifdef UART_RX_PARITY_EN
        return bus_if.parity_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_ok);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < DB; i++) drive(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ ~par_ok, BIT_CLK);
`endif
        drive(stop, BIT_CLK);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus_if.rx_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 00", bus_if.rx_data); end
        n_cmp++; if (bus_if.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus_if.rx_valid); end
        n_cmp++; if (bus_if.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", bus_if.frame_err); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        n_cmp++; if (cur_perr() !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b expected 0", cur_perr()); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_good_frame();
        int bv, bf;
        bv = n_valid; bf = n_ferr;
        send_frame(8'hA5, 1'b1, 1'b1);
        model_data = 8'hA5;
        drive(1'b1, 20);
        n_cmp++; if (n_valid - bv != 1) begin n_err++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid - bv); end
        n_cmp++; if (got_q.size() > bv && got_q[bv] !== 8'hA5) begin n_err++; $display("FAIL a5_pulse_data: got %h expected a5", got_q[bv]); end
        n_cmp++; if (bus_if.rx_data !== model_data) begin n_err++; $display("FAIL a5_data: got %h expected %h", bus_if.rx_data, model_data); end
        n_cmp++; if (n_ferr != bf) begin n_err++; $display("FAIL a5_ferr: got %0d expected 0", n_ferr - bf); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL a5_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_frame_err();
        int bv, bf;
        bv = n_valid; bf = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b1);
        drive(1'b1, 20);
        n_cmp++; if (n_ferr - bf != 1) begin n_err++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - bf); end
        n_cmp++; if (n_valid != bv) begin n_err++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - bv); end
        n_cmp++; if (bus_if.rx_data !== model_data) begin n_err++; $display("FAIL ferr_data: got %h expected %h", bus_if.rx_data, model_data); end
    endtask

    task automatic test_glitch();
        int bv, bf, waited;
        bv = n_valid; bf = n_ferr;
        drive(1'b0, 8);
        n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_hi: got %b expected 1", bus_if.busy); end
        drive(1'b0, 8);
        rx = 1'b1;
        waited = 0;
        while (bus_if.busy !== 1'b0 && waited < 8 * 4) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_lo: got %b expected 0 after %0d clk", bus_if.busy, waited); end
        drive(1'b1, BIT_CLK);
        n_cmp++; if (n_valid != bv || n_ferr != bf) begin n_err++; $display("FAIL glitch_pulses: got %0d/%0d expected 0/0", n_valid - bv, n_ferr - bf); end
    endtask

    task automatic test_break();
        int bv, bf;
        bv = n_valid; bf = n_ferr;
        drive(1'b0, 20 * BIT_CLK);
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL break_busy: got %b expected 0", bus_if.busy); end
        drive(1'b1, 2 * BIT_CLK);
        n_cmp++; if (n_ferr - bf != 1) begin n_err++; $display("FAIL break_ferr: got %0d expected 1", n_ferr - bf); end
        n_cmp++; if (n_valid != bv) begin n_err++; $display("FAIL break_valid: got %0d expected 0", n_valid - bv); end
    endtask

    task automatic test_back_to_back();
        int bv;
        bv = n_valid;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        model_data = 8'hFF;
        drive(1'b1, 32);
        n_cmp++; if (n_valid - bv != 2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", n_valid - bv); end
        n_cmp++; if (got_q.size() > bv && got_q[bv] !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h expected 00", got_q[bv]); end
        n_cmp++; if (got_q.size() > bv + 1 && got_q[bv+1] !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h expected ff", got_q[bv+1]); end
    endtask

    task automatic test_reset_midframe();
        int bv, bf;
        logic [DB-1:0] d;
        d = 8'h55;
        bv = n_valid; bf = n_ferr;
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(d[i], BIT_CLK);
        drive(d[4], BIT_CLK / 2);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        model_data = '0;
        n_cmp++; if (bus_if.rx_data !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h expected 00", bus_if.rx_data); end
        n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", bus_if.busy); end
        n_cmp++; if (bus_if.rx_valid !== 1'b0 || bus_if.frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulse: got %b%b expected 00", bus_if.rx_valid, bus_if.frame_err); end
        rst = 1'b0;
        drive(1'b1, 200);
        n_cmp++; if (n_valid != bv || n_ferr != bf) begin n_err++; $display("FAIL mid_rst_nopulse: got %0d/%0d expected 0/0", n_valid - bv, n_ferr - bf); end
        send_frame(8'h81, 1'b1, 1'b1);
        model_data = 8'h81;
        drive(1'b1, 20);
        n_cmp++; if (n_valid - bv != 1) begin n_err++; $display("FAIL after_rst_count: got %0d expected 1", n_valid - bv); end
        n_cmp++; if (bus_if.rx_data !== 8'h81) begin n_err++; $display("FAIL after_rst_data: got %h expected 81", bus_if.rx_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int bv, bf, bp;
        bv = n_valid; bf = n_ferr; bp = n_perr;
        send_frame(8'h07, 1'b1, 1'b0);
        drive(1'b1, 20);
        n_cmp++; if (n_perr - bp != 1) begin n_err++; $display("FAIL parity_err: got %0d expected 1", n_perr - bp); end
        n_cmp++; if (n_valid != bv) begin n_err++; $display("FAIL parity_valid: got %0d expected 0", n_valid - bv); end
        n_cmp++; if (n_ferr != bf) begin n_err++; $display("FAIL parity_ferr: got %0d expected 0", n_ferr - bf); end
        n_cmp++; if (bus_if.rx_data !== model_data) begin n_err++; $display("FAIL parity_data: got %h expected %h", bus_if.rx_data, model_data); end
    endtask
`endif

    task automatic test_random();
        int bv, bf, bp, bb, exp_f, exp_p;
        logic [DB-1:0] exp_q[$];
        logic [DB-1:0] d;
        logic stop, par_ok;
        int gap;
        bv = n_valid; bf = n_ferr; bp = n_perr; bb = n_both;
        exp_f = 0; exp_p = 0;
        for (int i = 0; i < 14; i++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            par_ok = ($urandom_range(0, 3) != 0);
`else
            par_ok = 1'b1;
`endif
            send_frame(d, stop, par_ok);
            if (stop && par_ok) begin
                exp_q.push_back(d);
                model_data = d;
            end
            if (!stop) exp_f++;
            if (!par_ok) exp_p++;
            gap = stop ? int'($urandom_range(0, 80)) : BIT_CLK + int'($urandom_range(0, 40));
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, 40);
        n_cmp++; if (n_valid - bv != exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", n_valid - bv, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q.size() > bv + i) begin
                n_cmp++; if (got_q[bv+i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[bv+i], exp_q[i]); end
            end
        end
        n_cmp++; if (n_ferr - bf != exp_f) begin n_err++; $display("FAIL rand_ferr: got %0d expected %0d", n_ferr - bf, exp_f); end
        n_cmp++; if (n_perr - bp != exp_p) begin n_err++; $display("FAIL rand_perr: got %0d expected %0d", n_perr - bp, exp_p); end
        n_cmp++; if (n_both != bb) begin n_err++; $display("FAIL rand_both: got %0d expected 0", n_both - bb); end
        n_cmp++; if (bus_if.rx_data !== model_data) begin n_err++; $display("FAIL rand_hold: got %h expected %h", bus_if.rx_data, model_data); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within 5 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_frame_err();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        n_cmp++; if (n_both != 0) begin n_err++; $display("FAIL valid_ferr_together: got %0d expected 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
